// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer.
//   - INTCON bit positions
//   - sequencer state encoding
//   - default interrupt vector address
package interrupt_sequencer_pkg;

   localparam int GIE_BIT  = 7;
   localparam int PEIE_BIT = 6;
   localparam int T0IE_BIT = 5;
   localparam int INTE_BIT = 4;
   localparam int RBIE_BIT = 3;
   localparam int T0IF_BIT = 2;
   localparam int INTF_BIT = 1;
   localparam int RBIF_BIT = 0;

   localparam logic [12:0] DEFAULT_VECTOR_ADDR = 13'h004;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_WAKE      = 3'd1,
      ST_ENTRY_NOP = 3'd2,
      ST_ENTRY_VEC = 3'd3,
      ST_ISR       = 3'd4
   } irq_state_e;

endpackage

// File: rtl/irq_source_mux.sv
// Interrupt source qualification.
// Combines enable/flag pairs from INTCON and the peripheral PIE1/PIR1 bank.
// Ports:
//   intcon_in  - INTCON register value
//   pie1_in    - peripheral interrupt enables
//   pir1_in    - peripheral interrupt flags
//   flag_any   - at least one enabled source is flagged (ignores GIE)
//   pending    - flag_any qualified by GIE
module irq_source_mux
   import interrupt_sequencer_pkg::*;
(
   input  logic [7:0] intcon_in,
   input  logic [7:0] pie1_in,
   input  logic [7:0] pir1_in,
   output logic       flag_any,
   output logic       pending
);

   logic core_src;
   logic periph_src;

   assign core_src = (intcon_in[T0IE_BIT] & intcon_in[T0IF_BIT])
                   | (intcon_in[INTE_BIT] & intcon_in[INTF_BIT])
                   | (intcon_in[RBIE_BIT] & intcon_in[RBIF_BIT]);

   assign periph_src = intcon_in[PEIE_BIT] & (|(pie1_in & pir1_in));

   assign flag_any = core_src | periph_src;
   assign pending  = intcon_in[GIE_BIT] & flag_any;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer for the midrange core.
// Decides at instruction boundaries whether to pre-empt program flow, then
// runs the fixed entry: forced NOP cycle(s), then a vector cycle that pushes
// the return PC, loads the vector and clears GIE. Tracks the ISR until
// RETFIE and issues SLEEP wake-ups.
// Ports:
//   clk, rst          - core clock, synchronous active-high reset
//   cycle_end         - Q4 pulse of every instruction cycle
//   instr_done        - final cycle of the current instruction ends
//   instr_is_retfie   - completing instruction is RETFIE
//   sleep_active      - core is in SLEEP
//   intcon_in/pie1_in/pir1_in - interrupt register values
//   pc_in             - current PC, captured as return address
//   irq_flush, pc_hold         - held through the whole entry sequence
//   stack_push_en/data         - return address push (pulse)
//   pc_vector_en/addr          - vector load (pulse) and fixed address
//   gie_clr_en, gie_set_en     - INTCON GIE write strobes (pulses)
//   wake              - leave SLEEP (pulse)
//   in_isr            - inside the interrupt service routine
//   irq_count         - saturating count of interrupts taken
//
// state        | meaning
// ST_RUN       | normal execution, watching for entry / wake
// ST_WAKE      | reserved encoding, falls back to ST_RUN
// ST_ENTRY_NOP | forced NOP instruction cycles before the vector
// ST_ENTRY_VEC | vector cycle: push, jump and GIE clear on its cycle_end
// ST_ISR       | servicing, waiting for RETFIE (no nesting)
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
#(
   parameter logic [12:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR,
   parameter int          ENTRY_NOPS  = 1,
   parameter int          CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cycle_end,
   input  logic             instr_done,
   input  logic             instr_is_retfie,
   input  logic             sleep_active,
   input  logic [7:0]       intcon_in,
   input  logic [7:0]       pie1_in,
   input  logic [7:0]       pir1_in,
   input  logic [12:0]      pc_in,
   output logic             irq_flush,
   output logic             pc_hold,
   output logic             stack_push_en,
   output logic [12:0]      stack_push_data,
   output logic             pc_vector_en,
   output logic [12:0]      pc_vector_addr,
   output logic             gie_clr_en,
   output logic             gie_set_en,
   output logic             wake,
   output logic             in_isr,
   output logic [CNT_W-1:0] irq_count
);

   // NOP cycle timer counts down to zero; the last NOP cycle is the one
   // whose cycle_end sees a terminal count.
   localparam logic [1:0] NOP_LOAD = 2'(ENTRY_NOPS - 1);

   irq_state_e       state, state_nxt;
   logic [1:0]       nop_cnt, nop_cnt_nxt;
   logic [12:0]      saved_pc, saved_pc_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   logic flag_any;
   logic pending;
   logic take_entry;
   logic entry_pulse;
   logic set_pulse;
   logic wake_pulse;
   logic flush_c;

   irq_source_mux u_src (
      .intcon_in (intcon_in),
      .pie1_in   (pie1_in),
      .pir1_in   (pir1_in),
      .flag_any  (flag_any),
      .pending   (pending)
   );

   // A boundary entry needs a finished instruction; a sleep wake-up with
   // GIE set enters regardless, since no instruction is executing.
   assign take_entry = cycle_end & ((instr_done & pending) | (sleep_active & pending));

   always_comb begin
      state_nxt    = state;
      nop_cnt_nxt  = nop_cnt;
      saved_pc_nxt = saved_pc;
      cnt_nxt      = irq_count;
      entry_pulse  = 1'b0;
      set_pulse    = 1'b0;
      wake_pulse   = 1'b0;
      flush_c      = 1'b0;

      case (state)
         ST_RUN: begin
            if (cycle_end && sleep_active && flag_any) begin
               wake_pulse = 1'b1;
            end
            if (take_entry) begin
               saved_pc_nxt = pc_in;
               nop_cnt_nxt  = NOP_LOAD;
               state_nxt    = ST_ENTRY_NOP;
            end
         end

         ST_ENTRY_NOP: begin
            flush_c = 1'b1;
            if (cycle_end) begin
               if (nop_cnt == 2'd0) begin
                  state_nxt = ST_ENTRY_VEC;
               end else begin
                  nop_cnt_nxt = nop_cnt - 2'd1;
               end
            end
         end

         ST_ENTRY_VEC: begin
            flush_c = 1'b1;
            if (cycle_end) begin
               entry_pulse = 1'b1;
               cnt_nxt     = (&irq_count) ? irq_count : irq_count + CNT_W'(1);
               state_nxt   = ST_ISR;
            end
         end

         ST_ISR: begin
            if (cycle_end && instr_done && instr_is_retfie) begin
               set_pulse = 1'b1;
               state_nxt = ST_RUN;
            end
         end

         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         nop_cnt   <= 2'd0;
         saved_pc  <= 13'd0;
         irq_count <= '0;
      end else begin
         state     <= state_nxt;
         nop_cnt   <= nop_cnt_nxt;
         saved_pc  <= saved_pc_nxt;
         irq_count <= cnt_nxt;
      end
   end

   // Strobes are masked by rst so a reset landing on a cycle_end never
   // leaves a partial push, vector load or GIE write behind.
   assign stack_push_en   = entry_pulse & ~rst;
   assign pc_vector_en    = entry_pulse & ~rst;
   assign gie_clr_en      = entry_pulse & ~rst;
   assign gie_set_en      = set_pulse & ~rst;
   assign wake            = wake_pulse & ~rst;
   assign stack_push_data = saved_pc;
   assign pc_vector_addr  = VECTOR_ADDR;
   assign irq_flush       = flush_c;
   assign pc_hold         = flush_c;
   assign in_isr          = (state == ST_ISR);

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

   localparam logic [12:0] VEC = 13'h004;

   logic        clk;
   logic        rst;
   logic        cycle_end;
   logic        instr_done;
   logic        instr_is_retfie;
   logic        sleep_active;
   logic [7:0]  intcon_in;
   logic [7:0]  pie1_in;
   logic [7:0]  pir1_in;
   logic [12:0] pc_in;
   logic        irq_flush;
   logic        pc_hold;
   logic        stack_push_en;
   logic [12:0] stack_push_data;
   logic        pc_vector_en;
   logic [12:0] pc_vector_addr;
   logic        gie_clr_en;
   logic        gie_set_en;
   logic        wake;
   logic        in_isr;
   logic [7:0]  irq_count;

   int n_chk  = 0;
   int n_fail = 0;

   interrupt_sequencer #(
      .VECTOR_ADDR (13'h004),
      .ENTRY_NOPS  (1),
      .CNT_W       (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cycle_end       (cycle_end),
      .instr_done      (instr_done),
      .instr_is_retfie (instr_is_retfie),
      .sleep_active    (sleep_active),
      .intcon_in       (intcon_in),
      .pie1_in         (pie1_in),
      .pir1_in         (pir1_in),
      .pc_in           (pc_in),
      .irq_flush       (irq_flush),
      .pc_hold         (pc_hold),
      .stack_push_en   (stack_push_en),
      .stack_push_data (stack_push_data),
      .pc_vector_en    (pc_vector_en),
      .pc_vector_addr  (pc_vector_addr),
      .gie_clr_en      (gie_clr_en),
      .gie_set_en      (gie_set_en),
      .wake            (wake),
      .in_isr          (in_isr),
      .irq_count       (irq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        ce;
      logic        done;
      logic        ret;
      logic        slp;
      logic [7:0]  intcon;
      logic [7:0]  pie;
      logic [7:0]  pir;
      logic [12:0] pc;
      logic        e_flush;
      logic        e_ent;
      logic [12:0] e_data;
      logic        e_set;
      logic        e_wake;
      logic        e_isr;
      logic [7:0]  e_cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic rst_v, input logic ce, input logic done, input logic ret, input logic slp,
      input logic [7:0] intcon, input logic [7:0] pie, input logic [7:0] pir, input logic [12:0] pc,
      input logic e_flush, input logic e_ent, input logic [12:0] e_data, input logic e_set,
      input logic e_wake, input logic e_isr, input logic [7:0] e_cnt);
      vec_t v;
      v.rst = rst_v; v.ce = ce; v.done = done; v.ret = ret; v.slp = slp;
      v.intcon = intcon; v.pie = pie; v.pir = pir; v.pc = pc;
      v.e_flush = e_flush; v.e_ent = e_ent; v.e_data = e_data; v.e_set = e_set;
      v.e_wake = e_wake; v.e_isr = e_isr; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
      end
   endtask

   // Drive just after a rising edge, check at the falling edge, then let
   // the next rising edge commit the cycle.
   task automatic run_row(input int row, input vec_t v);
      #1;
      rst             = v.rst;
      cycle_end       = v.ce;
      instr_done      = v.done;
      instr_is_retfie = v.ret;
      sleep_active    = v.slp;
      intcon_in       = v.intcon;
      pie1_in         = v.pie;
      pir1_in         = v.pir;
      pc_in           = v.pc;
      @(negedge clk);
      if (!v.rst) begin
         chk("irq_flush", row, 32'(irq_flush), 32'(v.e_flush));
         chk("pc_hold",   row, 32'(pc_hold),   32'(v.e_flush));
         chk("in_isr",    row, 32'(in_isr),    32'(v.e_isr));
         chk("irq_count", row, 32'(irq_count), 32'(v.e_cnt));
      end
      chk("stack_push_en",  row, 32'(stack_push_en),  32'(v.e_ent));
      chk("pc_vector_en",   row, 32'(pc_vector_en),   32'(v.e_ent));
      chk("gie_clr_en",     row, 32'(gie_clr_en),     32'(v.e_ent));
      chk("gie_set_en",     row, 32'(gie_set_en),     32'(v.e_set));
      chk("wake",           row, 32'(wake),           32'(v.e_wake));
      chk("pc_vector_addr", row, 32'(pc_vector_addr), 32'(VEC));
      if (v.e_ent) begin
         chk("stack_push_data", row, 32'(stack_push_data), 32'(v.e_data));
      end
      @(posedge clk);
   endtask

   vec_t tbl [42];

   initial begin
      // r0-r14: reset state, basic T0 entry, no nesting, RETFIE with flags
      // still set, re-entry once GIE returns
      tbl[0]  = mk(0,0,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd0);
      tbl[1]  = mk(0,1,1,0,0, 8'hA4,8'h00,8'h00,13'h0123, 0,0,13'h0000,0,0,0,8'd0);
      tbl[2]  = mk(0,0,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd0);
      tbl[3]  = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd0);
      tbl[4]  = mk(0,0,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd0);
      tbl[5]  = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,1,13'h0123,0,0,0,8'd0);
      tbl[6]  = mk(0,0,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,1,8'd1);
      tbl[7]  = mk(0,1,1,0,0, 8'hA4,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,1,8'd1);
      tbl[8]  = mk(0,1,0,1,0, 8'hA4,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,1,8'd1);
      tbl[9]  = mk(0,1,1,1,0, 8'h24,8'h00,8'h00,13'h0000, 0,0,13'h0000,1,0,1,8'd1);
      tbl[10] = mk(0,1,1,0,0, 8'h24,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd1);
      tbl[11] = mk(0,1,1,0,0, 8'hA4,8'h00,8'h00,13'h0200, 0,0,13'h0000,0,0,0,8'd1);
      tbl[12] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd1);
      tbl[13] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,1,13'h0200,0,0,0,8'd1);
      tbl[14] = mk(0,1,1,1,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,1,0,1,8'd2);
      // r15-r20: pending during first cycle of a 2-cycle branch
      tbl[15] = mk(0,1,0,0,0, 8'hA4,8'h00,8'h00,13'h0050, 0,0,13'h0000,0,0,0,8'd2);
      tbl[16] = mk(0,0,0,0,0, 8'hA4,8'h00,8'h00,13'h0050, 0,0,13'h0000,0,0,0,8'd2);
      tbl[17] = mk(0,1,1,0,0, 8'hA4,8'h00,8'h00,13'h0300, 0,0,13'h0000,0,0,0,8'd2);
      tbl[18] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd2);
      tbl[19] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,1,13'h0300,0,0,0,8'd2);
      tbl[20] = mk(0,1,1,1,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,1,0,1,8'd3);
      // r21-r26: sleep wake with GIE=0 (wake only), then GIE=1 (wake + entry)
      tbl[21] = mk(0,1,0,0,1, 8'h12,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,1,0,8'd3);
      tbl[22] = mk(0,0,0,0,1, 8'h12,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd3);
      tbl[23] = mk(0,1,0,0,1, 8'h92,8'h00,8'h00,13'h0400, 0,0,13'h0000,0,1,0,8'd3);
      tbl[24] = mk(0,1,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd3);
      tbl[25] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,1,13'h0400,0,0,0,8'd3);
      tbl[26] = mk(0,1,1,1,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,1,0,1,8'd4);
      // r27-r33: peripheral source with simultaneous sleep wake, PEIE gating, RB source
      tbl[27] = mk(0,1,1,0,1, 8'hC0,8'h01,8'h01,13'h0555, 0,0,13'h0000,0,1,0,8'd4);
      tbl[28] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd4);
      tbl[29] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,1,13'h0555,0,0,0,8'd4);
      tbl[30] = mk(0,1,1,1,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,1,0,1,8'd5);
      tbl[31] = mk(0,1,1,0,0, 8'hC0,8'h01,8'h02,13'h0111, 0,0,13'h0000,0,0,0,8'd5);
      tbl[32] = mk(0,1,1,0,0, 8'h80,8'h01,8'h01,13'h0111, 0,0,13'h0000,0,0,0,8'd5);
      tbl[33] = mk(0,1,1,0,0, 8'h89,8'h00,8'h00,13'h1FFF, 0,0,13'h0000,0,0,0,8'd5);
      // r34-r41: reset during ENTRY_NOP and on the ENTRY_VEC cycle_end
      tbl[34] = mk(1,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd5);
      tbl[35] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd0);
      tbl[36] = mk(0,1,1,0,0, 8'hA4,8'h00,8'h00,13'h0123, 0,0,13'h0000,0,0,0,8'd0);
      tbl[37] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd0);
      tbl[38] = mk(1,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 1,0,13'h0000,0,0,0,8'd0);
      tbl[39] = mk(0,0,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd0);
      tbl[40] = mk(0,1,1,0,1, 8'h80,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd0);
      tbl[41] = mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'd0);

      rst = 1'b1; cycle_end = 1'b0; instr_done = 1'b0; instr_is_retfie = 1'b0;
      sleep_active = 1'b0; intcon_in = 8'h00; pie1_in = 8'h00; pir1_in = 8'h00;
      pc_in = 13'h0000;
      @(posedge clk);
      @(posedge clk);

      for (int i = 0; i < 42; i++) begin
         run_row(i, tbl[i]);
      end

      // Saturation: 256 back-to-back entries starting from a zero count.
      for (int k = 0; k < 256; k++) begin
         logic [7:0]  c_before;
         logic [7:0]  c_after;
         logic [12:0] pc_k;
         c_before = (k > 255) ? 8'hFF : 8'(k);
         c_after  = (k >= 255) ? 8'hFF : 8'(k + 1);
         pc_k     = 13'h0100 + 13'(k);
         run_row(100 + k * 4 + 0, mk(0,1,1,0,0, 8'hA4,8'h00,8'h00,pc_k,      0,0,13'h0000,0,0,0,c_before));
         run_row(100 + k * 4 + 1, mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000,  1,0,13'h0000,0,0,0,c_before));
         run_row(100 + k * 4 + 2, mk(0,1,1,0,0, 8'h00,8'h00,8'h00,13'h0000,  1,1,pc_k,     0,0,0,c_before));
         run_row(100 + k * 4 + 3, mk(0,1,1,1,0, 8'h00,8'h00,8'h00,13'h0000,  0,0,13'h0000,1,0,1,c_after));
      end
      run_row(2000, mk(0,0,0,0,0, 8'h00,8'h00,8'h00,13'h0000, 0,0,13'h0000,0,0,0,8'hFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
